// File: rtl/strength_fmt_pkg.sv
// strength_fmt_pkg
// Shared types and constants for the %v strength-format decoder:
//   strength_e  - 3-bit drive strength code (Hi=0 .. Su=7)
//   value_e     - 2-bit logic value code (0, 1, X, Z)
//   dec_state_e - decoder FSM state encoding
//   CH_*        - ASCII separator, mnemonic and value character constants
// No ports (package).
package strength_fmt_pkg;

  typedef enum logic [2:0] {
    STR_HI = 3'd0,
    STR_SM = 3'd1,
    STR_ME = 3'd2,
    STR_WE = 3'd3,
    STR_LA = 3'd4,
    STR_PU = 3'd5,
    STR_ST = 3'd6,
    STR_SU = 3'd7
  } strength_e;

  typedef enum logic [1:0] {
    VAL_0 = 2'd0,
    VAL_1 = 2'd1,
    VAL_X = 2'd2,
    VAL_Z = 2'd3
  } value_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GOT1   = 2'd1,
    ST_GOT2   = 2'd2,
    ST_RESYNC = 2'd3
  } dec_state_e;

  // separators
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // mnemonic letters
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_U  = 8'h75;  // 'u'
  localparam logic [7:0] CH_T  = 8'h74;  // 't'
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_A  = 8'h61;  // 'a'
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_E  = 8'h65;  // 'e'
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_LM = 8'h6D;  // 'm'
  localparam logic [7:0] CH_H  = 8'h48;
  localparam logic [7:0] CH_I  = 8'h69;  // 'i'

  // value characters
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_Z  = 8'h5A;
  localparam logic [7:0] CH_LX = 8'h78;  // 'x'
  localparam logic [7:0] CH_LZ = 8'h7A;  // 'z'

  function automatic logic is_sep(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_CR) || (c == CH_LF);
  endfunction

  function automatic logic is_first_letter(input logic [7:0] c);
    return (c == CH_S) || (c == CH_P) || (c == CH_L) ||
           (c == CH_W) || (c == CH_M) || (c == CH_H);
  endfunction

endpackage

// File: rtl/strength_fmt_decoder_if.sv
// strength_fmt_decoder_if
// Character-in / token-out stream bundle for the strength-format decoder.
//   in_valid, in_char[7:0], in_ready          - ASCII character stream
//   out_valid, out_ready                      - token handshake
//   out_value[1:0], out_strength[2:0], out_error - decoded token
// master: stream source and token sink; slave: the decoder.
interface strength_fmt_decoder_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_value;
  logic [2:0] out_strength;
  logic       out_error;

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_value, out_strength, out_error
  );

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_value, out_strength, out_error
  );
endinterface

// File: rtl/strength_mnemonic_lut.sv
// strength_mnemonic_lut
// Combinational two-letter mnemonic to strength code lookup (case-exact).
//   c0[7:0]   in  - first mnemonic letter
//   c1[7:0]   in  - second mnemonic letter
//   strength  out - strength code (STR_HI when not legal)
//   legal     out - 1 when {c0,c1} is one of Su St Pu La We Me Sm Hi
module strength_mnemonic_lut
  import strength_fmt_pkg::*;
(
  input  logic [7:0] c0,
  input  logic [7:0] c1,
  output strength_e  strength,
  output logic       legal
);

  always_comb begin
    strength = STR_HI;
    legal    = 1'b1;
    case ({c0, c1})
      {CH_S, CH_U}:  strength = STR_SU;
      {CH_S, CH_T}:  strength = STR_ST;
      {CH_P, CH_U}:  strength = STR_PU;
      {CH_L, CH_A}:  strength = STR_LA;
      {CH_W, CH_E}:  strength = STR_WE;
      {CH_M, CH_E}:  strength = STR_ME;
      {CH_S, CH_LM}: strength = STR_SM;
      {CH_H, CH_I}:  strength = STR_HI;
      default:       legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/strength_fmt_decoder.sv
// strength_fmt_decoder
// Decodes a %v-format ASCII stream of three-character tokens
// (strength mnemonic + value char) into value/strength codes.
//   clk          in  - clock, rising edge
//   rst          in  - asynchronous active-high reset
//   bus (slave)      - in_valid/in_char/in_ready character stream,
//                      out_valid/out_ready token handshake with
//                      out_value, out_strength, out_error
// Parameter ACCEPT_LOWER: accept 'x'/'z' as 'X'/'Z'.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | between tokens, separators consumed silently
// GOT1      | first mnemonic letter held
// GOT2      | full mnemonic held, waiting for value char
// RESYNC    | after an error, drop chars until a separator
module strength_fmt_decoder
  import strength_fmt_pkg::*;
#(
  parameter bit ACCEPT_LOWER = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  strength_fmt_decoder_if.slave bus
);

  dec_state_e state_q, state_d;
  logic [7:0] c0_q;
  strength_e  str_q;

  logic       out_valid_q, out_error_q;
  logic [1:0] out_value_q;
  logic [2:0] out_strength_q;
  logic       pend_err_q;

  logic [7:0] ch;
  logic       accept, slot_free;
  strength_e  lut_str;
  logic       lut_legal;
  value_e     val;
  logic       val_legal;

  logic       ld_c0, ld_str, emit, emit_err;
  value_e     emit_val;
  strength_e  emit_str;

  assign ch        = bus.in_char;
  // Only a char in GOT1/GOT2 can complete a token, so only there must we
  // stall while the output slot is occupied.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready &&
                          (state_q == ST_GOT1 || state_q == ST_GOT2));
  assign accept    = bus.in_valid && bus.in_ready;
  assign slot_free = !out_valid_q || bus.out_ready;

  strength_mnemonic_lut u_lut (
    .c0       (c0_q),
    .c1       (ch),
    .strength (lut_str),
    .legal    (lut_legal)
  );

  always_comb begin
    val       = VAL_0;
    val_legal = 1'b1;
    case (ch)
      CH_0:  val = VAL_0;
      CH_1:  val = VAL_1;
      CH_X:  val = VAL_X;
      CH_Z:  val = VAL_Z;
      CH_LX: begin val = VAL_X; val_legal = ACCEPT_LOWER; end
      CH_LZ: begin val = VAL_Z; val_legal = ACCEPT_LOWER; end
      default: val_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_c0    = 1'b0;
    ld_str   = 1'b0;
    emit     = 1'b0;
    emit_err = 1'b0;
    emit_val = VAL_0;
    emit_str = STR_HI;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (is_sep(ch)) begin
            state_d = ST_IDLE;
          end else if (is_first_letter(ch)) begin
            state_d = ST_GOT1;
            ld_c0   = 1'b1;
          end else begin
            state_d  = ST_RESYNC;
            emit     = 1'b1;
            emit_err = 1'b1;
          end
        end
        ST_GOT1: begin
          // the LUT rejects separators and non-ASCII bytes as well
          if (lut_legal) begin
            state_d = ST_GOT2;
            ld_str  = 1'b1;
          end else begin
            state_d  = ST_RESYNC;
            emit     = 1'b1;
            emit_err = 1'b1;
          end
        end
        ST_GOT2: begin
          // Z belongs to Hi and Hi only takes Z
          if (val_legal && ((str_q == STR_HI) == (val == VAL_Z))) begin
            state_d  = ST_IDLE;
            emit     = 1'b1;
            emit_val = val;
            emit_str = str_q;
          end else begin
            state_d  = ST_RESYNC;
            emit     = 1'b1;
            emit_err = 1'b1;
          end
        end
        default: begin
          if (is_sep(ch)) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_q <= 8'h00;
      str_q <= STR_HI;
    end else begin
      if (ld_c0)  c0_q  <= ch;
      if (ld_str) str_q <= lut_str;
    end
  end

  // An error found in IDLE while the output is stalled cannot be refused,
  // so it is parked in pend_err_q and issued once the slot frees. Further
  // errors arriving while one is parked collapse into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_error_q    <= 1'b0;
      out_value_q    <= 2'd0;
      out_strength_q <= 3'd0;
      pend_err_q     <= 1'b0;
    end else if (slot_free) begin
      if (pend_err_q) begin
        out_valid_q    <= 1'b1;
        out_error_q    <= 1'b1;
        out_value_q    <= 2'd0;
        out_strength_q <= 3'd0;
        pend_err_q     <= emit;
      end else if (emit) begin
        out_valid_q    <= 1'b1;
        out_error_q    <= emit_err;
        out_value_q    <= emit_val;
        out_strength_q <= emit_str;
      end else begin
        out_valid_q    <= 1'b0;
      end
    end else if (emit) begin
      pend_err_q <= 1'b1;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_error    = out_error_q;
  assign bus.out_value    = out_value_q;
  assign bus.out_strength = out_strength_q;

endmodule
